// File: rtl/pkt_header_parser.sv
// pkt_header_parser
// Hunts for an 8-bit preamble in a serial bit/strobe stream, then deserializes
// the SRC, DEST, FREQ, LEN, SIZE and CRC fields MSB-first. It reports a
// complete header with a one-cycle hdr_valid pulse.
// Build option: define HDR_CRC_CHECK_EN to check a CRC-16/CCITT computed over
// the SRC..SIZE bits against the received CRC field. A mismatch turns the
// hdr_valid pulse into an hdr_err pulse.
module pkt_header_parser #(
  parameter logic [7:0]  PREAMBLE = 8'hFE,
  parameter int unsigned HUNT_MAX = 64
) (
  input  logic        core_clock,
  input  logic        core_rst,
  input  logic        req,
  input  logic        bit_vld,
  input  logic        bit_in,
  output logic        busy,
  output logic        hdr_valid,
  output logic [7:0]  src_addr,
  output logic [7:0]  dest_addr,
  output logic [7:0]  clock_freq,
  output logic [15:0] data_length,
  output logic [15:0] data_size,
  output logic [15:0] data_crc,
  output logic        hdr_err,
  output logic        hunt_timeout
);

  typedef enum logic [3:0] {
    ST_IDLE = 4'd0,
    ST_HUNT = 4'd1,
    ST_SRC  = 4'd2,
    ST_DEST = 4'd3,
    ST_FREQ = 4'd4,
    ST_LEN  = 4'd5,
    ST_SIZE = 4'd6,
    ST_CRC  = 4'd7,
    ST_DONE = 4'd8
  } state_t;

  localparam logic [7:0] HUNT_MAX_C = 8'(HUNT_MAX);

  state_t      state_r;
  state_t      state_s;
  state_t      fld_next_s;

  logic [7:0]  shreg_r;
  logic [7:0]  shreg_nxt_s;
  logic [7:0]  hunt_cnt_r;
  logic [7:0]  hunt_cnt_inc_s;
  logic [3:0]  fld_cnt_r;

  logic        take_s;
  logic        match_s;
  logic        hunt_hit_s;
  logic        in_field_s;
  logic        fld_last_s;
  logic        crc_ok_s;

  logic        hdr_valid_s;
  logic        hdr_err_s;
  logic        hunt_timeout_s;

  logic        busy_r;
  logic        hdr_valid_r;
  logic        hdr_err_r;
  logic        hunt_timeout_r;

  logic [7:0]  src_addr_r;
  logic [7:0]  dest_addr_r;
  logic [7:0]  clock_freq_r;
  logic [15:0] data_length_r;
  logic [15:0] data_size_r;
  logic [15:0] data_crc_r;
  logic [15:0] crc_final_s;

  // A bit only counts while the request is still up; an abort discards it.
  assign take_s      = req & bit_vld;
  assign hunt_hit_s  = (state_r == ST_HUNT) & take_s & match_s;
  assign crc_final_s = {data_crc_r[14:0], bit_in};

`ifdef HDR_CRC_CHECK_EN
  logic [15:0] crc_r;
  logic        crc_cover_s;

  // One serial step of CRC-16/CCITT (poly 0x1021), MSB-first.
  function automatic logic [15:0] crc16_step(input logic [15:0] crc,
                                             input logic        din);
    logic        fb;
    logic [15:0] shifted;
    fb      = crc[15] ^ din;
    shifted = {crc[14:0], 1'b0};
    if (fb) begin
      crc16_step = shifted ^ 16'h1021;
    end else begin
      crc16_step = shifted;
    end
  endfunction

  assign crc_cover_s = in_field_s & (state_r != ST_CRC);
  assign crc_ok_s    = (crc_r == crc_final_s);

  // Running CRC over the SRC..SIZE bits, seeded when the preamble is found.
  always_ff @(posedge core_clock or posedge core_rst) begin
    if (core_rst) begin
      crc_r <= 16'h0000;
    end else if (hunt_hit_s) begin
      crc_r <= 16'hFFFF;
    end else if (take_s && crc_cover_s) begin
      crc_r <= crc16_step(crc_r, bit_in);
    end
  end
`else
  assign crc_ok_s = 1'b1;
`endif

  // Preamble window and saturating hunt counter arithmetic.
  always_comb begin
    shreg_nxt_s = {shreg_r[6:0], bit_in};
    match_s     = (shreg_nxt_s == PREAMBLE);
    if (hunt_cnt_r == 8'hFF) begin
      hunt_cnt_inc_s = 8'hFF;
    end else begin
      hunt_cnt_inc_s = hunt_cnt_r + 8'd1;
    end
  end

  // Field length, successor state and field-state flag for the current state.
  always_comb begin
    fld_last_s = 1'b0;
    fld_next_s = ST_IDLE;
    in_field_s = 1'b0;
    case (state_r)
      ST_SRC: begin
        in_field_s = 1'b1;
        fld_last_s = (fld_cnt_r == 4'd7);
        fld_next_s = ST_DEST;
      end
      ST_DEST: begin
        in_field_s = 1'b1;
        fld_last_s = (fld_cnt_r == 4'd7);
        fld_next_s = ST_FREQ;
      end
      ST_FREQ: begin
        in_field_s = 1'b1;
        fld_last_s = (fld_cnt_r == 4'd7);
        fld_next_s = ST_LEN;
      end
      ST_LEN: begin
        in_field_s = 1'b1;
        fld_last_s = (fld_cnt_r == 4'd15);
        fld_next_s = ST_SIZE;
      end
      ST_SIZE: begin
        in_field_s = 1'b1;
        fld_last_s = (fld_cnt_r == 4'd15);
        fld_next_s = ST_CRC;
      end
      ST_CRC: begin
        in_field_s = 1'b1;
        fld_last_s = (fld_cnt_r == 4'd15);
        fld_next_s = ST_DONE;
      end
      default: begin
        in_field_s = 1'b0;
        fld_last_s = 1'b0;
        fld_next_s = ST_IDLE;
      end
    endcase
  end

  // Next-state decode plus the pulses that accompany each transition.
  always_comb begin
    state_s        = state_r;
    hdr_valid_s    = 1'b0;
    hdr_err_s      = 1'b0;
    hunt_timeout_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (req) begin
          state_s = ST_HUNT;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_HUNT: begin
        if (!req) begin
          state_s = ST_IDLE;
        end else if (bit_vld) begin
          if (match_s) begin
            state_s = ST_SRC;
          end else if (hunt_cnt_inc_s >= HUNT_MAX_C) begin
            state_s        = ST_IDLE;
            hunt_timeout_s = 1'b1;
          end else begin
            state_s = ST_HUNT;
          end
        end else begin
          state_s = ST_HUNT;
        end
      end
      ST_SRC, ST_DEST, ST_FREQ, ST_LEN, ST_SIZE, ST_CRC: begin
        if (!req) begin
          state_s   = ST_IDLE;
          hdr_err_s = 1'b1;
        end else if (bit_vld && fld_last_s) begin
          state_s = fld_next_s;
          if (state_r == ST_CRC) begin
            if (crc_ok_s) begin
              hdr_valid_s = 1'b1;
            end else begin
              hdr_err_s = 1'b1;
            end
          end else begin
            hdr_valid_s = 1'b0;
          end
        end else begin
          state_s = state_r;
        end
      end
      ST_DONE: begin
        if (!req) begin
          state_s = ST_IDLE;
        end else begin
          state_s = ST_DONE;
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge core_clock or posedge core_rst) begin
    if (core_rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Status outputs registered from the decoded transition, so each pulse lands in the target state's cycle.
  always_ff @(posedge core_clock or posedge core_rst) begin
    if (core_rst) begin
      busy_r         <= 1'b0;
      hdr_valid_r    <= 1'b0;
      hdr_err_r      <= 1'b0;
      hunt_timeout_r <= 1'b0;
    end else begin
      busy_r         <= (state_s != ST_IDLE);
      hdr_valid_r    <= hdr_valid_s;
      hdr_err_r      <= hdr_err_s;
      hunt_timeout_r <= hunt_timeout_s;
    end
  end

  // Preamble shift register and hunt bit counter; both restart on each hunt.
  always_ff @(posedge core_clock or posedge core_rst) begin
    if (core_rst) begin
      shreg_r    <= 8'h00;
      hunt_cnt_r <= 8'h00;
    end else if ((state_r == ST_IDLE) && req) begin
      shreg_r    <= 8'h00;
      hunt_cnt_r <= 8'h00;
    end else if ((state_r == ST_HUNT) && take_s) begin
      shreg_r <= shreg_nxt_s;
      if (match_s) begin
        hunt_cnt_r <= 8'h00;
      end else begin
        hunt_cnt_r <= hunt_cnt_inc_s;
      end
    end
  end

  // Per-field bit counter; wraps to zero at the end of every field.
  always_ff @(posedge core_clock or posedge core_rst) begin
    if (core_rst) begin
      fld_cnt_r <= 4'd0;
    end else if (hunt_hit_s) begin
      fld_cnt_r <= 4'd0;
    end else if (take_s && in_field_s) begin
      if (fld_last_s) begin
        fld_cnt_r <= 4'd0;
      end else begin
        fld_cnt_r <= fld_cnt_r + 4'd1;
      end
    end
  end

  // Field deserializers: cleared when the preamble hits, then shifted live.
  always_ff @(posedge core_clock or posedge core_rst) begin
    if (core_rst) begin
      src_addr_r    <= 8'h00;
      dest_addr_r   <= 8'h00;
      clock_freq_r  <= 8'h00;
      data_length_r <= 16'h0000;
      data_size_r   <= 16'h0000;
      data_crc_r    <= 16'h0000;
    end else if (hunt_hit_s) begin
      src_addr_r    <= 8'h00;
      dest_addr_r   <= 8'h00;
      clock_freq_r  <= 8'h00;
      data_length_r <= 16'h0000;
      data_size_r   <= 16'h0000;
      data_crc_r    <= 16'h0000;
    end else if (take_s) begin
      case (state_r)
        ST_SRC:  src_addr_r    <= {src_addr_r[6:0], bit_in};
        ST_DEST: dest_addr_r   <= {dest_addr_r[6:0], bit_in};
        ST_FREQ: clock_freq_r  <= {clock_freq_r[6:0], bit_in};
        ST_LEN:  data_length_r <= {data_length_r[14:0], bit_in};
        ST_SIZE: data_size_r   <= {data_size_r[14:0], bit_in};
        ST_CRC:  data_crc_r    <= crc_final_s;
        default: begin
        end
      endcase
    end
  end

  assign busy         = busy_r;
  assign hdr_valid    = hdr_valid_r;
  assign hdr_err      = hdr_err_r;
  assign hunt_timeout = hunt_timeout_r;
  assign src_addr     = src_addr_r;
  assign dest_addr    = dest_addr_r;
  assign clock_freq   = clock_freq_r;
  assign data_length  = data_length_r;
  assign data_size    = data_size_r;
  assign data_crc     = data_crc_r;

endmodule

// File: tb/tb_pkt_header_parser.sv
// Self-checking bench for pkt_header_parser. It drives randomized bit streams
// with random strobe gaps. A reference model locates the preamble in the stream,
// slices out the fields and predicts which pulse appears and in which cycle.
module tb_pkt_header_parser;

  localparam int         HUNT_MAX  = 64;
  localparam logic [7:0] PRE       = 8'hFE;
  localparam int         K_NONE    = 0;
  localparam int         K_VALID   = 1;
  localparam int         K_CRCERR  = 2;
  localparam int         K_TIMEOUT = 3;

  logic        core_clock = 1'b0;
  logic        core_rst;
  logic        req;
  logic        bit_vld;
  logic        bit_in;
  logic        busy;
  logic        hdr_valid;
  logic        hdr_err;
  logic        hunt_timeout;
  logic [7:0]  src_addr;
  logic [7:0]  dest_addr;
  logic [7:0]  clock_freq;
  logic [15:0] data_length;
  logic [15:0] data_size;
  logic [15:0] data_crc;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int valid_n = 0;
  int err_n   = 0;
  int to_n    = 0;
  int both_n  = 0;
  int valid_cyc = -1;
  int err_cyc   = -1;
  int to_cyc    = -1;
  logic to_busy = 1'b1;

  logic        stream_q[$];
  int          acc_cyc[$];
  int          exp_kind;
  int          exp_idx;
  logic [71:0] exp_hdr;

  pkt_header_parser dut (
    .core_clock  (core_clock),
    .core_rst    (core_rst),
    .req         (req),
    .bit_vld     (bit_vld),
    .bit_in      (bit_in),
    .busy        (busy),
    .hdr_valid   (hdr_valid),
    .src_addr    (src_addr),
    .dest_addr   (dest_addr),
    .clock_freq  (clock_freq),
    .data_length (data_length),
    .data_size   (data_size),
    .data_crc    (data_crc),
    .hdr_err     (hdr_err),
    .hunt_timeout(hunt_timeout)
  );

  always #5 core_clock = ~core_clock;

  always @(posedge core_clock) cyc <= cyc + 1;

  // Pulse monitor, sampled mid-cycle.
  always @(negedge core_clock) begin
    if (hdr_valid) begin valid_n++; valid_cyc = cyc; end
    if (hdr_err) begin err_n++; err_cyc = cyc; end
    if (hunt_timeout) begin to_n++; to_cyc = cyc; to_busy = busy; end
    if (hdr_valid && hdr_err) both_n++;
  end

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge core_clock);
    #1;
  endtask

  task automatic push_bits(input logic [15:0] v, input int n);
    for (int k = n - 1; k >= 0; k--) stream_q.push_back(v[k]);
  endtask

  task automatic push_nominal();
    push_bits(16'(PRE), 8);
    push_bits(16'h0000, 8);
    push_bits(16'h00F8, 8);
    push_bits(16'h0001, 8);
    push_bits(16'h0003, 16);
    push_bits(16'h0000, 16);
    push_bits(16'hFFFF, 16);
  endtask

  function automatic logic [15:0] crc16(input logic [55:0] d);
    logic [15:0] c;
    c = 16'hFFFF;
    for (int i = 55; i >= 0; i--) begin
      if (c[15] ^ d[i]) c = {c[14:0], 1'b0} ^ 16'h1021;
      else              c = {c[14:0], 1'b0};
    end
    return c;
  endfunction

  // Reference model: first preamble window inside the hunt limit, then 72 field bits.
  task automatic model();
    int         m;
    logic [7:0] w;
    m = -1;
    for (int i = 7; i < stream_q.size() && i < HUNT_MAX && m < 0; i++) begin
      for (int k = 0; k < 8; k++) w[7-k] = stream_q[i-7+k];
      if (w == PRE) m = i;
    end
    exp_hdr = '0;
    exp_idx = 0;
    if (m < 0) begin
      if (stream_q.size() >= HUNT_MAX) begin
        exp_kind = K_TIMEOUT;
        exp_idx  = HUNT_MAX - 1;
      end else begin
        exp_kind = K_NONE;
      end
    end else if (stream_q.size() < m + 73) begin
      exp_kind = K_NONE;
    end else begin
      for (int j = 0; j < 72; j++) exp_hdr[71-j] = stream_q[m+1+j];
      exp_idx = m + 72;
`ifdef HDR_CRC_CHECK_EN
      exp_kind = (crc16(exp_hdr[71:16]) == exp_hdr[15:0]) ? K_VALID : K_CRCERR;
`else
      exp_kind = K_VALID;
`endif
    end
  endtask

  task automatic drive_bits(input int gmin, input int gmax);
    for (int i = 0; i < stream_q.size(); i++) begin
      bit_vld = 1'b1;
      bit_in  = stream_q[i];
      step();
      acc_cyc.push_back(cyc);
      bit_vld = 1'b0;
      bit_in  = 1'b0;
      repeat ($urandom_range(gmax, gmin)) step();
    end
  endtask

  task automatic run_stream(input string tag, input int gmin, input int gmax);
    int v0, e0, t0;
    model();
    v0 = valid_n; e0 = err_n; t0 = to_n;
    acc_cyc.delete();
    req = 1'b1; bit_vld = 1'b0;
    step();
    drive_bits(gmin, gmax);
    repeat (2) step();
    case (exp_kind)
      K_VALID: begin
        check_eq({tag, "_nvalid"}, 64'(valid_n - v0), 64'd1);
        check_eq({tag, "_nerr"}, 64'(err_n - e0), 64'd0);
        check_eq({tag, "_latency"}, 64'(valid_cyc), 64'(acc_cyc[exp_idx]));
      end
      K_CRCERR: begin
        check_eq({tag, "_nerr"}, 64'(err_n - e0), 64'd1);
        check_eq({tag, "_nvalid"}, 64'(valid_n - v0), 64'd0);
        check_eq({tag, "_err_latency"}, 64'(err_cyc), 64'(acc_cyc[exp_idx]));
      end
      K_TIMEOUT: begin
        check_eq({tag, "_nto"}, 64'(to_n - t0), 64'd1);
        check_eq({tag, "_nvalid"}, 64'(valid_n - v0), 64'd0);
        check_eq({tag, "_to_latency"}, 64'(to_cyc), 64'(acc_cyc[exp_idx]));
        check_eq({tag, "_to_busy"}, 64'(to_busy), 64'd0);
      end
      default: begin
        check_eq({tag, "_model_kind"}, 64'(exp_kind), 64'(K_VALID));
      end
    endcase
    if (exp_kind == K_VALID || exp_kind == K_CRCERR) begin
      check_eq({tag, "_nto"}, 64'(to_n - t0), 64'd0);
      check_eq({tag, "_addr"}, 64'({src_addr, dest_addr, clock_freq}), 64'(exp_hdr[71:48]));
      check_eq({tag, "_len_size"}, 64'({data_length, data_size}), 64'(exp_hdr[47:16]));
      check_eq({tag, "_crc"}, 64'(data_crc), 64'(exp_hdr[15:0]));
    end
    req = 1'b0;
    step();
    step();
    check_eq({tag, "_busy_end"}, 64'(busy), 64'd0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [55:0] h;
    logic [15:0] c;
    int          e0;
    core_rst = 1'b0; req = 1'b0; bit_vld = 1'b0; bit_in = 1'b0;
    #2 core_rst = 1'b1;
    #1;
    check_eq("rst_ctl", 64'({busy, hdr_valid, hdr_err, hunt_timeout}), 64'd0);
    check_eq("rst_addr", 64'({src_addr, dest_addr, clock_freq}), 64'd0);
    check_eq("rst_len", 64'({data_length, data_size, data_crc}), 64'd0);
    step(); step();
    core_rst = 1'b0;
    step();

    // Nominal header, one bit every two cycles.
    stream_q.delete(); push_nominal();
    run_stream("nom", 1, 1);
    check_eq("nom_src", 64'(src_addr), 64'h00);
    check_eq("nom_dest", 64'(dest_addr), 64'hF8);
    check_eq("nom_freq", 64'(clock_freq), 64'h01);
    check_eq("nom_len", 64'(data_length), 64'h0003);
    check_eq("nom_size", 64'(data_size), 64'h0000);
    check_eq("nom_crc", 64'(data_crc), 64'hFFFF);

    // Junk bits ahead of the preamble.
    stream_q.delete();
    push_bits(16'h0016, 5);
    push_nominal();
    run_stream("junk", 1, 1);
    check_eq("junk_dest", 64'(dest_addr), 64'hF8);
    check_eq("junk_len", 64'(data_length), 64'h0003);

    // All-zero hunt timeout, then randomized no-preamble streams.
    stream_q.delete();
    for (int i = 0; i < HUNT_MAX; i++) stream_q.push_back(1'b0);
    run_stream("hunt_zero", 0, 1);
    for (int t = 0; t < 3; t++) begin
      stream_q.delete();
      for (int i = 0; i < HUNT_MAX; i++)
        stream_q.push_back((i % 4 == 3) ? 1'b0 : 1'($urandom_range(1, 0)));
      run_stream("hunt_rnd", 0, 2);
    end

    // Abort after the 3rd DEST bit; request drop coincides with a strobe.
    stream_q.delete();
    push_bits(16'(PRE), 8);
    push_bits(16'h005A, 8);
    push_bits(16'h0005, 3);
    e0 = err_n;
    req = 1'b1; step();
    drive_bits(0, 2);
    req = 1'b0; bit_vld = 1'b1; bit_in = 1'b1;
    step();
    bit_vld = 1'b0; bit_in = 1'b0;
    check_eq("abort_err", 64'(hdr_err), 64'd1);
    check_eq("abort_valid", 64'(hdr_valid), 64'd0);
    check_eq("abort_busy", 64'(busy), 64'd0);
    step();
    check_eq("abort_err_width", 64'(hdr_err), 64'd0);
    check_eq("abort_nerr", 64'(err_n - e0), 64'd1);
    stream_q.delete(); push_nominal();
    run_stream("after_abort", 0, 2);

    // Reset while inside LEN, then restart with req held high.
    stream_q.delete(); push_nominal();
    while (stream_q.size() > 37) void'(stream_q.pop_back());
    req = 1'b1; step();
    drive_bits(0, 1);
    core_rst = 1'b1;
    #1;
    check_eq("midrst_ctl", 64'({busy, hdr_valid, hdr_err, hunt_timeout}), 64'd0);
    check_eq("midrst_addr", 64'({src_addr, dest_addr, clock_freq}), 64'd0);
    check_eq("midrst_len", 64'({data_length, data_size, data_crc}), 64'd0);
    step();
    core_rst = 1'b0;
    stream_q.delete(); push_nominal();
    run_stream("after_rst", 0, 2);

    // Randomized headers with random junk, gaps and trailing payload.
    for (int t = 0; t < 16; t++) begin
      stream_q.delete();
      repeat ($urandom_range(40, 0)) stream_q.push_back(1'($urandom_range(1, 0)));
      push_bits(16'(PRE), 8);
      h = 56'({$urandom, $urandom});
      c = 16'($urandom);
      if (t % 2 == 0) c = crc16(h);
      push_bits(h[55:40], 16);
      push_bits(h[39:24], 16);
      push_bits(h[23:8], 16);
      push_bits(16'(h[7:0]), 8);
      push_bits(c, 16);
      repeat ($urandom_range(6, 0)) stream_q.push_back(1'($urandom_range(1, 0)));
      run_stream("rnd", 0, 3);
    end

    check_eq("valid_err_overlap", 64'(both_n), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
